// File: rtl/trace_pkg.sv
// trace_pkg
//   Shared definitions for the instruction trace capture block:
//   - FSM state encoding (IDLE/ARMED/CAPTURE/DONE)
//   - record field widths and bit offsets inside a trace record
//   - default FIFO depth and stamp width
//   - saturating 8-bit increment used by the drop counter
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_STAMP_W = 16;

    // Record body layout, LSB first: wb_data, rd, wb_en, pc. The stamp sits above.
    localparam int PC_W        = 32;
    localparam int RD_W        = 5;
    localparam int WB_W        = 32;
    localparam int WB_DATA_LSB = 0;
    localparam int RD_LSB      = WB_DATA_LSB + WB_W;
    localparam int WB_EN_LSB   = RD_LSB + RD_W;
    localparam int PC_LSB      = WB_EN_LSB + 1;
    localparam int REC_BODY_W  = PC_LSB + PC_W;
    localparam int STAMP_LSB   = REC_BODY_W;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   First-word-fall-through FIFO holding trace records.
//   Ports:
//     clk, rst      clock, synchronous active-low reset (pointers/occupancy only)
//     wr_en/wr_data push request; accepted when not full, or when full with a pop
//     rd_en         pop request; ignored while empty
//     rd_data       head record, zero while empty
//     full, empty   status flags
//     count         occupancy, 0..DEPTH
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    // Data is masked while empty so a freshly written slot is not visible
    // before the push edge completes.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap naturally modulo DEPTH.
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/trace_capture.sv
// trace_capture
//   Captures retiring-instruction records into a FIFO once a trigger PC is
//   seen, tagging each with a cycle stamp counted from arm.
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     arm, stop                control pulses (arm wins when both are high)
//     trig_pc, cap_len         trigger PC and record limit (0 = unlimited)
//     commit_*                 retirement interface
//     trc_valid/ready/data     FWFT record stream {stamp, pc, wb_en, rd, wb_data}
//     state                    FSM state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
//     overflow, drop_cnt       sticky drop flag and saturating drop count
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int STAMP_W = DEFAULT_STAMP_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arm,
    input  logic                          stop,
    input  logic [31:0]                   trig_pc,
    input  logic [7:0]                    cap_len,
    input  logic                          commit_valid,
    input  logic [31:0]                   commit_pc,
    input  logic                          commit_wb_en,
    input  logic [4:0]                    commit_rd,
    input  logic [31:0]                   commit_wb_data,
    output logic                          trc_valid,
    input  logic                          trc_ready,
    output logic [STAMP_W+REC_BODY_W-1:0] trc_data,
    output logic [1:0]                    state,
    output logic                          overflow,
    output logic [7:0]                    drop_cnt
);

    localparam int REC_W = STAMP_W + REC_BODY_W;
    localparam int AW    = $clog2(DEPTH);

    trace_state_e      state_q, state_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [7:0]        count_q, count_d, count_inc;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d;
    logic              rec_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;
    logic [REC_W-1:0]  rec_data;

    assign rec_data  = {stamp_q, commit_pc, commit_wb_en, commit_rd, commit_wb_data};
    assign trc_valid = !fifo_empty;
    assign fifo_pop  = trc_valid && trc_ready;
    assign count_inc = count_q + 8'd1;
    assign state     = state_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        state_d    = state_q;
        stamp_d    = stamp_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        rec_push   = 1'b0;

        if (state_q == ST_ARMED || state_q == ST_CAPTURE) stamp_d = stamp_q + STAMP_W'(1);

        if (arm) begin
            // Re-arm from any state; FIFO contents are deliberately kept.
            state_d    = ST_ARMED;
            stamp_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (stop) state_d = ST_DONE;
                    else if (commit_valid && commit_pc == trig_pc) begin
                        rec_push = 1'b1;
                        state_d  = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (stop) state_d = ST_DONE;
                    else if (commit_valid) rec_push = 1'b1;
                end
                ST_DONE: begin
                    if (fifo_count == '0) state_d = ST_IDLE;
                end
            endcase
        end

        if (rec_push) begin
            // Dropped records still count toward cap_len.
            count_d = count_inc;
            if (cap_len != 8'd0 && count_inc == cap_len) state_d = ST_DONE;
            if (fifo_full && !fifo_pop) begin
                overflow_d = 1'b1;
                drop_d     = sat_inc8(drop_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            stamp_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            stamp_q    <= stamp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rec_push),
        .wr_data (rec_data),
        .rd_en   (trc_ready),
        .rd_data (trc_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture
//   Bench for trace_capture (DEPTH=8, STAMP_W=4): table-driven trigger/limit
//   sequence, hand-written corner sequences, and randomized episodes checked
//   against a queue-based reference model every cycle.
module tb_trace_capture;

    localparam int DEPTH     = 8;
    localparam int SW        = 4;
    localparam int STAMP_MOD = 1 << SW;
    localparam int RW        = SW + 70;

    typedef logic [RW-1:0] rec_t;

    logic        clk;
    logic        rst, arm, stop;
    logic [31:0] trig_pc;
    logic [7:0]  cap_len;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_wb_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_wb_data;
    logic        trc_valid, trc_ready;
    logic [RW-1:0] trc_data;
    logic [1:0]  state;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    trace_capture #(.DEPTH(DEPTH), .STAMP_W(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .stop           (stop),
        .trig_pc        (trig_pc),
        .cap_len        (cap_len),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_wb_en   (commit_wb_en),
        .commit_rd      (commit_rd),
        .commit_wb_data (commit_wb_data),
        .trc_valid      (trc_valid),
        .trc_ready      (trc_ready),
        .trc_data       (trc_data),
        .state          (state),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    int   m_state, m_stamp, m_count, m_drops;
    bit   m_ovf;
    rec_t m_q[$];

    function automatic void model_edge();
        bit   pop, rec, active;
        rec_t r;
        int   nstate, nstamp;
        logic [SW-1:0] st;
        if (!rst) begin
            m_state = 0; m_stamp = 0; m_count = 0; m_ovf = 0; m_drops = 0;
            m_q.delete();
            return;
        end
        active = (m_state == 1 || m_state == 2);
        pop    = (m_q.size() > 0) && trc_ready;
        rec    = 0;
        nstate = m_state;
        nstamp = active ? (m_stamp + 1) % STAMP_MOD : m_stamp;
        if (arm) begin
            nstate = 1; nstamp = 0; m_count = 0; m_ovf = 0; m_drops = 0;
        end else if (active && stop) nstate = 3;
        else if (m_state == 1) rec = commit_valid && (commit_pc == trig_pc);
        else if (m_state == 2) rec = commit_valid;
        else if (m_state == 3 && m_q.size() == 0) nstate = 0;
        st = m_stamp[SW-1:0];
        r  = {st, commit_pc, commit_wb_en, commit_rd, commit_wb_data};
        if (rec) begin
            m_count = (m_count + 1) % 256;
            nstate  = (cap_len != 0 && m_count == int'(cap_len)) ? 3 : 2;
        end
        if (pop) void'(m_q.pop_front());
        if (rec) begin
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        m_state = nstate;
        m_stamp = nstamp;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        rec_t head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        chk("model_state", state, m_state);
        chk("model_valid", trc_valid, m_q.size() > 0);
        chk("model_data", trc_data, head);
        chk("model_overflow", overflow, m_ovf);
        chk("model_drop_cnt", drop_cnt, m_drops);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic quiet();
        arm = 0; stop = 0; commit_valid = 0; commit_pc = 0;
        commit_wb_en = 0; commit_rd = 0; commit_wb_data = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid   = 1;
        commit_pc      = pc;
        commit_wb_en   = pc[2];
        commit_rd      = pc[6:2];
        commit_wb_data = ~pc;
    endtask

    // Drain with ready=1, checking each head PC against the list; bounded.
    task automatic drain(input logic [31:0] exp_pcs[$], input string tag);
        int n = 0;
        quiet();
        trc_ready = 1;
        for (int k = 0; k < 20 && trc_valid; k++) begin
            if (n < exp_pcs.size()) chk({tag, "_drain_pc"}, trc_data[69:38], exp_pcs[n]);
            n++;
            step();
        end
        chk({tag, "_drain_count"}, n, exp_pcs.size());
        trc_ready = 0;
    endtask

    typedef struct {
        bit          arm;
        bit          stop;
        bit          cv;
        logic [31:0] pc;
        bit          rdy;
        int          exp_state;
        bit          exp_valid;
        logic [31:0] exp_pc;
        int          exp_stamp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] exp_pcs[$];
        int ready_pct;

        tbl[0] = '{1, 0, 0, 32'h00, 0, 1, 0, 32'h00, 0};
        tbl[1] = '{0, 0, 1, 32'h38, 0, 1, 0, 32'h00, 0};
        tbl[2] = '{0, 0, 1, 32'h3C, 0, 1, 0, 32'h00, 0};
        tbl[3] = '{0, 0, 1, 32'h40, 0, 2, 1, 32'h40, 2};
        tbl[4] = '{0, 0, 1, 32'h44, 0, 3, 1, 32'h40, 2};
        tbl[5] = '{0, 0, 1, 32'h48, 1, 3, 1, 32'h44, 3};
        tbl[6] = '{0, 0, 0, 32'h00, 1, 3, 0, 32'h00, 0};
        tbl[7] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0};

        rst = 0; trc_ready = 0; trig_pc = 32'h40; cap_len = 8'd2;
        quiet();

        // Reset state
        do_reset();
        chk("reset_state", state, 0);
        chk("reset_valid", trc_valid, 0);
        chk("reset_data", trc_data, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_drop", drop_cnt, 0);

        // Trigger and cap_len=2 table
        for (int i = 0; i < 8; i++) begin
            arm = tbl[i].arm; stop = tbl[i].stop; trc_ready = tbl[i].rdy;
            if (tbl[i].cv) commit(tbl[i].pc);
            else begin commit_valid = 0; commit_pc = 0; end
            step();
            chk($sformatf("vec%0d_state", i), state, tbl[i].exp_state);
            chk($sformatf("vec%0d_valid", i), trc_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), trc_data[69:38], tbl[i].exp_pc);
                chk($sformatf("vec%0d_stamp", i), trc_data[73:70], tbl[i].exp_stamp);
            end
        end
        quiet(); trc_ready = 0;

        // Overflow with 10 commits, then full+pop+push, then ordered drain
        do_reset();
        trig_pc = 32'h40; cap_len = 0;
        arm = 1; step(); arm = 0;
        for (int i = 0; i < 10; i++) begin commit(32'h40 + 4 * i); step(); end
        chk("ovf_drop_cnt", drop_cnt, 2);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head_pc", trc_data[69:38], 32'h40);
        chk("ovf_state", state, 2);
        trc_ready = 1; commit(32'h100); step();
        chk("fullpop_drop_cnt", drop_cnt, 2);
        chk("fullpop_head_pc", trc_data[69:38], 32'h44);
        quiet(); trc_ready = 0; stop = 1; step(); stop = 0;
        chk("ovf_stop_state", state, 3);
        exp_pcs = {32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h100};
        drain(exp_pcs, "ovf");
        step();
        chk("ovf_idle_after_drain", state, 0);

        // Stop together with a commit
        arm = 1; step(); arm = 0;
        commit(32'h40); step();
        commit(32'h44); step();
        commit(32'h48); stop = 1; step(); stop = 0;
        chk("stop_state", state, 3);
        exp_pcs = {32'h40, 32'h44};
        drain(exp_pcs, "stop");
        step();
        chk("stop_idle_after_drain", state, 0);

        // Reset while 5 records are queued
        arm = 1; step(); arm = 0;
        for (int i = 0; i < 5; i++) begin commit(32'h40 + 4 * i); step(); end
        chk("rstq_valid_before", trc_valid, 1);
        quiet(); rst = 0; step(); rst = 1;
        chk("rstq_valid", trc_valid, 0);
        chk("rstq_state", state, 0);
        chk("rstq_drop", drop_cnt, 0);
        chk("rstq_data", trc_data, 0);

        // Stamp wrap: trigger 20 cycles after arm
        arm = 1; step(); arm = 0;
        repeat (20) step();
        commit(32'h40); step(); quiet();
        chk("stamp_wrap", trc_data[73:70], 4);
        chk("stamp_wrap_pc", trc_data[69:38], 32'h40);

        // arm and stop together: arm wins, FIFO kept
        arm = 1; stop = 1; step(); quiet();
        chk("armstop_state", state, 1);
        chk("armstop_fifo_kept", trc_valid, 1);
        do_reset();

        // Randomized episodes
        for (int e = 0; e < 40; e++) begin
            trig_pc   = 32'h40 + 4 * $urandom_range(0, 3);
            cap_len   = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            ready_pct = (e % 3 == 0) ? 10 : ((e % 3 == 1) ? 50 : 90);
            quiet(); arm = 1; step(); arm = 0;
            for (int c = 0; c < 60; c++) begin
                commit_valid   = ($urandom_range(0, 9) < 7);
                commit_pc      = 32'h40 + 4 * $urandom_range(0, 3);
                commit_wb_en   = 1'($urandom_range(0, 1));
                commit_rd      = 5'($urandom);
                commit_wb_data = $urandom;
                trc_ready      = ($urandom_range(0, 99) < ready_pct);
                stop           = ($urandom_range(0, 49) == 0);
                arm            = ($urandom_range(0, 79) == 0);
                rst            = !($urandom_range(0, 199) == 0);
                step();
            end
            quiet(); rst = 1; trc_ready = 1;
            repeat (12) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
